i2s_rx: RTL
===========

# i2s_rx

I2S serial receiver and deserializer, sitting directly downstream of the `i2stx` transmitter (loopback on board, or an external codec ADC). It oversamples `bclk`, `lrclk` and `din` on the 24.576 MHz master clock and extracts 32-bit left/right sample pairs. It presents each complete stereo frame as a parallel word pair with a one-cycle `valid` strobe. Framing errors are detected and reported, and the receiver re-locks automatically.

## Interface
- `BITS`, 32: bits per channel slot; also the output data width.
- `clk`  in  1: master clock, 24.576 MHz, same clock as the transmitter `mclk`.
- `nrst`  in  1: asynchronous active-low reset.
- `bclk`  in  1: serial bit clock; asynchronous to `clk`; min 2 `clk` periods high and 2 low.
- `lrclk`  in  1: word select; 0 = left, 1 = right.
- `din`  in  1: serial data, MSB first.
- `ldata`  out  BITS: last complete left sample.
- `rdata`  out  BITS: last complete right sample.
- `valid`  out  1: one-cycle pulse when `ldata`/`rdata` update together.
- `err`  out  1: one-cycle pulse on framing error.
- `locked`  out  1: high while frames are being received without error.

## Operation
- Format is left-justified, MSB-first, with no one-bit delay.
  - The bit sampled on the first `bclk` rise after an `lrclk` change is the MSB of the new slot.
  - `din` and `lrclk` change after the `bclk` fall.
- Input conditioning:
  - `bclk`, `lrclk` and `din` each pass through identical 2-flop synchronizers, so they see equal latency.
  - `bclk` rise is detected as synced-high AND previous-synced-low.
  - All logic below acts only in cycles with a `bclk` rise (`brise`).
- On `brise`: `shreg <= {shreg[BITS-2:0], din_s}`, `cnt <= cnt + 1`.
  - `cnt` is 6 bits and saturates at 63; it never wraps.
- Slot boundary is a `brise` where the sampled `lrclk` differs from the previous sampled `lrclk`.
  - At a boundary, `shreg`/`cnt` hold the completed previous slot.
  - The new slot then starts with `shreg <= {0.., din_s}` and `cnt <= 1`.
- State machine `st`:
  - `SYNC`: wait for the first boundary, then go to `LEFT` (if new `lrclk` = 0) or `RIGHT`. Data is discarded and `locked` = 0.
  - `LEFT`: at a boundary (0→1) with `cnt == BITS`, copy `shreg` to `lhold` and go to `RIGHT`.
  - `RIGHT`: at a boundary (1→0) with `cnt == BITS`:
    - `ldata <= lhold`, `rdata <= shreg`, `valid <= 1`, `locked <= 1`;
    - go to `LEFT`.
  - Error: any boundary with `cnt != BITS`, or `cnt` reaching 63 in `LEFT`/`RIGHT`:
    - `err <= 1`, `locked <= 0`, no `valid`;
    - go to `LEFT`/`RIGHT` according to the new `lrclk`, with the slot restarted as above. This is a re-lock with no pass through `SYNC`.
- A frame becomes valid only when it starts with a left slot. A right slot received first after `SYNC` is discarded without error.
- `ldata`/`rdata` hold their values between `valid` pulses and are not cleared on error.

## Timing
- Reset values:
  - `ldata` = 0, `rdata` = 0, `valid` = 0, `err` = 0, `locked` = 0;
  - synchronizers 0, `st` = `SYNC`, `cnt` = 0, `shreg` = 0, `lhold` = 0.
- Reset asserted mid-frame returns everything to the reset values immediately. After release the receiver re-enters `SYNC` and the first `valid` follows the next complete left+right pair.
- Latency: `valid`, `err`, `ldata` and `rdata` update on the 3rd `clk` rising edge, counting the edge that first captures the closing `bclk` high as edge 1.
- `valid` and `err` are exactly one `clk` wide and never high together.
- At the transmitter rate (512 `clk` per frame), `valid` pulses are exactly 512 cycles apart in steady state.
- Bits are taken only on `bclk` rise; `bclk` falls are ignored.

## Structure
- Shared package `i2s_pkg`:
  - state typedef `i2s_rx_state_t {SYNC, LEFT, RIGHT}`;
  - constants `I2S_BITS = 32`, `I2S_FS = 48000`, `I2S_FCLK = FS*512`.
- One sub-module, `sync2`: a 2-flop synchronizer with async active-low reset. Instantiate it three times.

## Test plan
- Reset: hold `nrst` = 0 with toggling inputs → all outputs 0 and `locked` = 0. Release → no `valid` before a full L+R pair.
- Basic frame from a BFM at 8 `clk`/bit, starting mid-right slot: L = 0x80000001, R = 0x7FFFFFFF.
  - The first right slot is discarded.
  - Then `valid` pulses once, with `ldata` = 0x80000001, `rdata` = 0x7FFFFFFF.
  - `locked` rises with that `valid`.
- Streaming: 48 frames with L = n, R = ~n.
  - Each `valid` is 512 `clk` apart and carries the matching pair.
  - No `err`.
- Short slot: 31 bits in the left slot.
  - `err` pulses at the 0→1 boundary; no `valid`; `locked` = 0.
  - The next full frame gives `valid` with correct data and `locked` = 1.
- Stuck `lrclk`: hold `lrclk` = 1 for 70 bits → `err` pulses once when `cnt` reaches 63, with no repeat pulses.
- Reset mid-right-slot: after release, `ldata` = 0 until the first complete new frame's `valid`.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path: receiver states and
// framing constants.
package i2s_pkg;

  // Receiver lock state: waiting for a slot edge, or inside a left/right slot.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam int unsigned I2S_BITS = 32;
  localparam int unsigned I2S_FS   = 48000;
  localparam int unsigned I2S_FCLK = I2S_FS * 512;

  // Per-slot bit counter width and its saturation value.
  localparam int unsigned I2S_CNT_W   = 6;
  localparam logic [5:0]  I2S_CNT_MAX = 6'd63;

endpackage

// File: rtl/i2s_rx_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset. Used once per
// serial input so bclk, lrclk and din all see the same latency.
module sync2 (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/din on clk, deserializes
// left-justified MSB-first slots and presents complete L/R pairs with a
// one-cycle valid strobe. Framing errors pulse err and the receiver re-locks
// on the current slot without returning to SYNC.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned BITS = I2S_BITS
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            bclk,
  input  logic            lrclk,
  input  logic            din,
  output logic [BITS-1:0] ldata,
  output logic [BITS-1:0] rdata,
  output logic            valid,
  output logic            err,
  output logic            locked
);

  logic bclk_s;
  logic lrclk_s;
  logic din_s;

  sync2 u_sync_bclk  (.clk(clk), .nrst(nrst), .d_i(bclk),  .q_o(bclk_s));
  sync2 u_sync_lrclk (.clk(clk), .nrst(nrst), .d_i(lrclk), .q_o(lrclk_s));
  sync2 u_sync_din   (.clk(clk), .nrst(nrst), .d_i(din),   .q_o(din_s));

  logic                 bclk_prev_q;
  logic                 lr_prev_q;
  logic                 primed_q;
  logic                 have_left_q;
  logic [I2S_CNT_W-1:0] cnt_q;
  logic [BITS-1:0]      shreg_q;
  logic [BITS-1:0]      lhold_q;
  logic [BITS-1:0]      ldata_q;
  logic [BITS-1:0]      rdata_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 locked_q;
  i2s_rx_state_t        st_q;

  logic                 brise;
  logic                 boundary;
  logic                 slot_full;
  logic                 overrun;
  logic [I2S_CNT_W-1:0] cnt_inc;
  i2s_rx_state_t        st_new_slot;

  assign brise = bclk_s & ~bclk_prev_q;

  // The first bclk rise after reset only records lrclk; without that a high
  // lrclk would look like an edge against the reset value of lr_prev_q.
  assign boundary  = primed_q && (lrclk_s != lr_prev_q);
  assign slot_full = (cnt_q == I2S_CNT_W'(BITS));
  assign cnt_inc   = (cnt_q == I2S_CNT_MAX) ? I2S_CNT_MAX : cnt_q + 1'b1;

  // A slot that would reach the saturation count is an error; it is flagged
  // on that bit and the slot restarts, so a stuck lrclk cannot re-flag on
  // every following bit.
  assign overrun = (st_q != SYNC) && !boundary &&
                   (cnt_q == I2S_CNT_MAX - 1'b1);

  assign st_new_slot = lrclk_s ? RIGHT : LEFT;

  // Edge history of the synchronized bit clock.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_s;
    end
  end

  // Deserializer and framing state machine; all outputs are registered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lr_prev_q   <= 1'b0;
      primed_q    <= 1'b0;
      have_left_q <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      lhold_q     <= '0;
      ldata_q     <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      st_q        <= SYNC;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (brise) begin
        primed_q  <= 1'b1;
        lr_prev_q <= lrclk_s;

        if (boundary || overrun) begin
          shreg_q <= {{(BITS-1){1'b0}}, din_s};
          cnt_q   <= I2S_CNT_W'(1);
        end else begin
          shreg_q <= {shreg_q[BITS-2:0], din_s};
          cnt_q   <= cnt_inc;
        end

        case (st_q)
          SYNC: begin
            have_left_q <= 1'b0;
            if (boundary) begin
              st_q <= st_new_slot;
            end
          end
          LEFT, RIGHT: begin
            if ((boundary && !slot_full) || overrun) begin
              err_q       <= 1'b1;
              locked_q    <= 1'b0;
              have_left_q <= 1'b0;
              st_q        <= st_new_slot;
            end else if (boundary) begin
              if (st_q == LEFT) begin
                lhold_q     <= shreg_q;
                have_left_q <= 1'b1;
                st_q        <= RIGHT;
              end else begin
                // A right slot without a preceding good left slot is dropped.
                if (have_left_q) begin
                  ldata_q  <= lhold_q;
                  rdata_q  <= shreg_q;
                  valid_q  <= 1'b1;
                  locked_q <= 1'b1;
                end
                have_left_q <= 1'b0;
                st_q        <= LEFT;
              end
            end
          end
          default: begin
            st_q <= SYNC;
          end
        endcase
      end
    end
  end

  assign ldata  = ldata_q;
  assign rdata  = rdata_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign locked = locked_q;

endmodule
